// File: rtl/operand_entry_if.sv
// Keypad-side and multiplier-side signals of the operand entry block.
// The slave modport is the entry block; the master drives keys and mult_ready.
interface operand_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       mult_ready;
  logic [7:0] num_1;
  logic [7:0] num_2;
  logic       valid;
  logic       operand_sel;
  logic [7:0] entry_mag;
  logic       entry_neg;
  logic       busy;
  logic       err;

  modport master (
    output key_valid, key_code, mult_ready,
    input  num_1, num_2, valid, operand_sel, entry_mag, entry_neg, busy, err
  );

  modport slave (
    input  key_valid, key_code, mult_ready,
    output num_1, num_2, valid, operand_sel, entry_mag, entry_neg, busy, err
  );
endinterface

// File: rtl/operand_entry.sv
// Decimal keypad entry of two signed 8-bit operands, then a one-cycle
// launch strobe to the multiplier and a wait for its completion pulse.
module operand_entry #(
  parameter int MAX_DIGITS = 3
) (
  input logic          clk,
  input logic          reset,
  operand_entry_if.slave bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, LAUNCH, WAIT_MULT} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mag_q, mag_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    num1_q, num1_d;
  logic [7:0]    num2_q, num2_d;
  logic          err_q, err_d;

  // Widened so an overflowing candidate (up to 128*10+9) is still comparable.
  logic [10:0] mag_next;
  logic [7:0]  twos_val;

  assign mag_next = ({3'b0, mag_q} * 11'd10) + {7'b0, bus.key_code};
  assign twos_val = neg_q ? (8'd0 - mag_q) : mag_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTER_A;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      num1_q  <= '0;
      num2_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    err_d   = 1'b0;
    case (state_q)
      ENTER_A, ENTER_B: begin
        if (bus.key_valid) begin
          if (bus.key_code <= 4'd9) begin
            if (cnt_q == CW'(MAX_DIGITS) || mag_next > 11'd128) begin
              err_d = 1'b1;
            end else begin
              mag_d = mag_next[7:0];
              cnt_d = cnt_q + 1'b1;
            end
          end else if (bus.key_code == 4'hA) begin
            // +128 has no 8-bit two's complement form; only -128 is legal.
            if (!neg_q && mag_q == 8'd128) begin
              err_d = 1'b1;
            end else begin
              if (state_q == ENTER_A) begin
                num1_d  = twos_val;
                state_d = ENTER_B;
              end else begin
                num2_d  = twos_val;
                state_d = LAUNCH;
              end
              mag_d = '0;
              neg_d = 1'b0;
              cnt_d = '0;
            end
          end else if (bus.key_code == 4'hB) begin
            neg_d = ~neg_q;
          end else if (bus.key_code == 4'hC) begin
            mag_d = '0;
            neg_d = 1'b0;
            cnt_d = '0;
          end
        end
      end
      LAUNCH:    state_d = WAIT_MULT;
      WAIT_MULT: if (bus.mult_ready) state_d = ENTER_A;
      default:   state_d = ENTER_A;
    endcase
  end

  assign bus.num_1       = num1_q;
  assign bus.num_2       = num2_q;
  assign bus.valid       = (state_q == LAUNCH);
  assign bus.busy        = (state_q == LAUNCH) || (state_q == WAIT_MULT);
  assign bus.operand_sel = (state_q == ENTER_B);
  assign bus.entry_mag   = mag_q;
  assign bus.entry_neg   = neg_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: directed scenarios plus randomized keys against
// a digit-list reference model.
module tb_operand_entry;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_entry_if bus ();
  operand_entry #(.MAX_DIGITS(3)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] K_ENT = 4'hA;
  localparam logic [3:0] K_NEG = 4'hB;
  localparam logic [3:0] K_CLR = 4'hC;

  // Drive one cycle; outputs are observed 1 time unit after the edge.
  task automatic cycle(input logic kv, input logic [3:0] kc, input logic mr);
    bus.key_valid  = kv;
    bus.key_code   = kc;
    bus.mult_ready = mr;
    @(posedge clk);
    #1;
    bus.key_valid  = 1'b0;
    bus.mult_ready = 1'b0;
  endtask

  task automatic press(input logic [3:0] kc);
    cycle(1'b1, kc, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  // Reference model: operand held as a list of typed digits plus a sign.
  int         m_phase;   // 0 entering A, 1 entering B, 2 launching, 3 waiting
  int         m_digits[$];
  bit         m_neg;
  logic [7:0] m_n1, m_n2;
  bit         m_err;

  function automatic int m_mag();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  function automatic void m_reset();
    m_phase = 0; m_digits.delete(); m_neg = 0; m_n1 = 0; m_n2 = 0; m_err = 0;
  endfunction

  function automatic void m_step(bit kv, int kc, bit mr);
    int v;
    m_err = 0;
    if (m_phase < 2) begin
      if (kv) begin
        if (kc <= 9) begin
          if (m_digits.size() == 3 || m_mag() * 10 + kc > 128) m_err = 1;
          else m_digits.push_back(kc);
        end else if (kc == 10) begin
          if (!m_neg && m_mag() == 128) m_err = 1;
          else begin
            v = m_neg ? -m_mag() : m_mag();
            if (m_phase == 0) m_n1 = 8'(v); else m_n2 = 8'(v);
            m_digits.delete(); m_neg = 0; m_phase++;
          end
        end else if (kc == 11) m_neg = !m_neg;
        else if (kc == 12) begin m_digits.delete(); m_neg = 0; end
      end
    end else if (m_phase == 2) m_phase = 3;
    else if (mr) m_phase = 0;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    press(4'd4); press(K_NEG);
    reset = 1'b1;
    cycle(1'b1, 4'd7, 1'b1);
    reset = 1'b0;
    checks++; if (bus.num_1 !== 8'h00) begin errors++; $display("FAIL reset_num_1: got %h want 00", bus.num_1); end
    checks++; if (bus.num_2 !== 8'h00) begin errors++; $display("FAIL reset_num_2: got %h want 00", bus.num_2); end
    checks++; if (bus.entry_mag !== 8'd0 || bus.entry_neg !== 1'b0) begin errors++; $display("FAIL reset_entry: got mag=%0d neg=%b want 0 0", bus.entry_mag, bus.entry_neg); end
    checks++; if ({bus.valid, bus.err, bus.busy, bus.operand_sel} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {bus.valid, bus.err, bus.busy, bus.operand_sel}); end
  endtask

  task automatic test_basic();
    int vcount;
    do_reset();
    press(4'd1); press(4'd2); press(K_ENT);
    checks++; if (bus.num_1 !== 8'h0C || bus.operand_sel !== 1'b1) begin errors++; $display("FAIL basic_num_1: got %h sel=%b want 0c sel=1", bus.num_1, bus.operand_sel); end
    press(K_NEG); press(4'd5);
    checks++; if (bus.entry_neg !== 1'b1 || bus.entry_mag !== 8'd5 || bus.valid !== 1'b0) begin errors++; $display("FAIL basic_echo: got neg=%b mag=%0d valid=%b want 1 5 0", bus.entry_neg, bus.entry_mag, bus.valid); end
    press(K_ENT);
    checks++; if (bus.num_2 !== 8'hFB || bus.valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_launch: got num_2=%h valid=%b busy=%b want fb 1 1", bus.num_2, bus.valid, bus.busy); end
    vcount = 0;
    repeat (3) begin idle(); if (bus.valid) vcount++; end
    checks++; if (vcount !== 0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_wait: got extra_valid=%0d busy=%b want 0 1", vcount, bus.busy); end
    cycle(1'b0, 4'h0, 1'b1);
    checks++; if (bus.operand_sel !== 1'b0 || bus.busy !== 1'b0 || bus.num_1 !== 8'h0C || bus.num_2 !== 8'hFB) begin errors++; $display("FAIL basic_done: got sel=%b busy=%b n1=%h n2=%h want 0 0 0c fb", bus.operand_sel, bus.busy, bus.num_1, bus.num_2); end
  endtask

  task automatic test_digit_limits();
    do_reset();
    press(4'd1); press(4'd2); press(4'd9);
    checks++; if (bus.err !== 1'b1 || bus.entry_mag !== 8'd12) begin errors++; $display("FAIL overflow_reject: got err=%b mag=%0d want 1 12", bus.err, bus.entry_mag); end
    idle();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_one_cycle: got %b want 0", bus.err); end
    press(K_CLR); press(4'd1); press(4'd0); press(4'd0);
    checks++; if (bus.err !== 1'b0 || bus.entry_mag !== 8'd100) begin errors++; $display("FAIL three_digits: got err=%b mag=%0d want 0 100", bus.err, bus.entry_mag); end
    press(4'd0);
    checks++; if (bus.err !== 1'b1 || bus.entry_mag !== 8'd100) begin errors++; $display("FAIL count_reject: got err=%b mag=%0d want 1 100", bus.err, bus.entry_mag); end
    press(4'hE);
    checks++; if (bus.err !== 1'b0 || bus.entry_mag !== 8'd100 || bus.operand_sel !== 1'b0) begin errors++; $display("FAIL ignored_code: got err=%b mag=%0d sel=%b want 0 100 0", bus.err, bus.entry_mag, bus.operand_sel); end
  endtask

  task automatic test_neg128();
    do_reset();
    press(K_NEG); press(4'd1); press(4'd2); press(4'd8); press(K_ENT);
    checks++; if (bus.num_1 !== 8'h80 || bus.operand_sel !== 1'b1) begin errors++; $display("FAIL neg128: got %h sel=%b want 80 1", bus.num_1, bus.operand_sel); end
    press(4'd1); press(4'd2); press(4'd8); press(K_ENT);
    checks++; if (bus.err !== 1'b1 || bus.operand_sel !== 1'b1 || bus.entry_mag !== 8'd128 || bus.busy !== 1'b0) begin errors++; $display("FAIL pos128_reject: got err=%b sel=%b mag=%0d busy=%b want 1 1 128 0", bus.err, bus.operand_sel, bus.entry_mag, bus.busy); end
  endtask

  task automatic test_wait_ignore();
    do_reset();
    press(4'd5); press(K_ENT); press(4'd3); press(K_ENT);
    idle();
    press(4'd7);
    checks++; if (bus.err !== 1'b0 || bus.entry_mag !== 8'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL wait_digit: got err=%b mag=%0d busy=%b want 0 0 1", bus.err, bus.entry_mag, bus.busy); end
    press(K_ENT);
    checks++; if (bus.num_2 !== 8'd3 || bus.busy !== 1'b1 || bus.valid !== 1'b0) begin errors++; $display("FAIL wait_enter: got n2=%h busy=%b valid=%b want 03 1 0", bus.num_2, bus.busy, bus.valid); end
    cycle(1'b1, 4'd3, 1'b1);
    checks++; if (bus.operand_sel !== 1'b0 || bus.busy !== 1'b0 || bus.entry_mag !== 8'd0 || bus.err !== 1'b0 || bus.num_1 !== 8'd5) begin errors++; $display("FAIL ready_with_key: got sel=%b busy=%b mag=%0d err=%b n1=%h want 0 0 0 0 05", bus.operand_sel, bus.busy, bus.entry_mag, bus.err, bus.num_1); end
  endtask

  task automatic test_reset_launch();
    int vcount;
    do_reset();
    press(4'd7); press(K_ENT); press(K_NEG); press(4'd2); press(K_ENT);
    checks++; if (bus.valid !== 1'b1 || bus.num_2 !== 8'hFE) begin errors++; $display("FAIL pre_abort: got valid=%b n2=%h want 1 fe", bus.valid, bus.num_2); end
    reset = 1'b1;
    idle();
    reset = 1'b0;
    checks++; if ({bus.valid, bus.busy, bus.operand_sel, bus.err} !== 4'b0000 || bus.num_1 !== 8'h00 || bus.num_2 !== 8'h00) begin errors++; $display("FAIL abort_state: got flags=%b n1=%h n2=%h want 0000 00 00", {bus.valid, bus.busy, bus.operand_sel, bus.err}, bus.num_1, bus.num_2); end
    vcount = 0;
    repeat (5) begin idle(); if (bus.valid) vcount++; end
    checks++; if (vcount !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", vcount); end
  endtask

  task automatic test_empty_operands();
    int vcount;
    do_reset();
    press(4'd9); press(K_CLR); press(K_ENT);
    vcount = 0;
    press(K_ENT);
    if (bus.valid) vcount++;
    repeat (4) begin idle(); if (bus.valid) vcount++; end
    checks++; if (bus.num_1 !== 8'h00 || bus.num_2 !== 8'h00 || vcount !== 1) begin errors++; $display("FAIL empty_operands: got n1=%h n2=%h pulses=%0d want 00 00 1", bus.num_1, bus.num_2, vcount); end
  endtask

  task automatic test_random();
    logic       kv, mr;
    logic [3:0] kc;
    int         r;
    do_reset();
    m_reset();
    for (int n = 0; n < 800; n++) begin
      kv = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 99);
      if (r < 60)      kc = 4'(r % 10);
      else if (r < 75) kc = K_ENT;
      else if (r < 83) kc = K_NEG;
      else if (r < 88) kc = K_CLR;
      else             kc = 4'(13 + r % 3);
      mr = ($urandom_range(0, 3) == 0);
      cycle(kv, kc, mr);
      m_step(kv, int'(kc), mr);
      checks++; if (bus.num_1 !== m_n1 || bus.num_2 !== m_n2) begin errors++; $display("FAIL rand_nums @%0d: got %h %h want %h %h", n, bus.num_1, bus.num_2, m_n1, m_n2); end
      checks++; if (bus.entry_mag !== 8'(m_mag()) || bus.entry_neg !== m_neg) begin errors++; $display("FAIL rand_entry @%0d: got mag=%0d neg=%b want %0d %b", n, bus.entry_mag, bus.entry_neg, m_mag(), m_neg); end
      checks++; if (bus.err !== m_err) begin errors++; $display("FAIL rand_err @%0d: got %b want %b", n, bus.err, m_err); end
      checks++; if (bus.valid !== (m_phase == 2) || bus.busy !== (m_phase >= 2)) begin errors++; $display("FAIL rand_flow @%0d: got valid=%b busy=%b want phase %0d", n, bus.valid, bus.busy, m_phase); end
      if (m_phase < 2) begin
        checks++; if (bus.operand_sel !== (m_phase == 1)) begin errors++; $display("FAIL rand_sel @%0d: got %b want %0d", n, bus.operand_sel, m_phase); end
      end
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'h0;
    bus.mult_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_digit_limits();
    test_neg128();
    test_wait_ignore();
    test_reset_launch();
    test_empty_operands();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
